// File: rtl/operand_sender.sv
// Operand sender: buffers host operand words, replays each as setup / rq pulse / hold transaction.
// Latency: push at edge N into idle empty block -> out_data at N+1, out_rq at N+2 for RQ_W cycles.
// Backpressure: sm_ready gates the IDLE pop only; full FIFO drops pushes and sets sticky overflow.

module operand_sender_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_vld,
  input  logic [DATA_W-1:0]        push_dat,
  input  logic                     pop_vld,
  output logic [DATA_W-1:0]        head_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  // Generic synchronous FIFO with registered occupancy count.
  // Latency: pushed word visible at head one cycle after the push edge.
  // Backpressure: push while full is accepted only when a pop happens in the same cycle.

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              push_ok;
  logic              pop_ok;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign head_dat = mem[rd_ptr_q];
  assign pop_ok   = pop_vld && !empty;
  assign push_ok  = push_vld && (!full || pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= push_dat;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

module operand_sender #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int RQ_W   = 1,
  parameter int GAP    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     sm_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_rq,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow
);
  // Paced operand transmitter into the control state machine in/rq inputs.
  // Latency: 2 cycles from push to rq rise; one word per 1+RQ_W+GAP+1 cycles.
  // Backpressure: sm_ready sampled only in IDLE; dropped pushes set sticky overflow.

  localparam int TMAX = (RQ_W > GAP) ? RQ_W : GAP;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t            state_q;
  state_t            state_nxt;
  logic [TW-1:0]     tmr_q;
  logic [TW-1:0]     tmr_nxt;
  logic [DATA_W-1:0] out_data_q;
  logic              out_rq_q;
  logic              ovf_q;
  logic              pop;
  logic              rq_nxt;
  logic              busy_d;
  logic [DATA_W-1:0] head_dat;

  operand_sender_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (wr_en),
    .push_dat (wr_data),
    .pop_vld  (pop),
    .head_dat (head_dat),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  // State register; out_rq is registered from the next state so it never glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tmr_q      <= '0;
      out_data_q <= '0;
      out_rq_q   <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      tmr_q    <= tmr_nxt;
      out_rq_q <= rq_nxt;
      if (pop) begin
        out_data_q <= head_dat;
      end
      if (wr_en && full && !pop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state_q;
    tmr_nxt   = tmr_q;
    case (state_q)
      IDLE: begin
        if (!empty && sm_ready) state_nxt = SETUP;
      end
      SETUP: begin
        state_nxt = PULSE;
        tmr_nxt   = TW'(RQ_W - 1);
      end
      PULSE: begin
        if (tmr_q == '0) begin
          state_nxt = HOLD;
          tmr_nxt   = TW'(GAP - 1);
        end else begin
          tmr_nxt = tmr_q - TW'(1);
        end
      end
      HOLD: begin
        if (tmr_q == '0) begin
          state_nxt = IDLE;
        end else begin
          tmr_nxt = tmr_q - TW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pop    = 1'b0;
    busy_d = 1'b1;
    rq_nxt = (state_nxt == PULSE);
    if (state_q == IDLE) begin
      busy_d = 1'b0;
      pop    = !empty && sm_ready;
    end
  end

  assign out_data = out_data_q;
  assign out_rq   = out_rq_q;
  assign busy     = busy_d;
  assign overflow = ovf_q;

endmodule
